bubble_dout_capture: RTL
========================

Name: bubble_dout_capture

Overview:
- Downstream consumer of the emulator core's bubble data outputs, used in on-board loopback and verification hardware.
- Operates in the MCLK domain and treats CLKOUT (4 MHz) as a sampling strobe.
- While the capture window nGATE is active, samples DOUT0..DOUT3 on every CLKOUT cycle, packs nibble pairs into bytes, and queues them in a show-ahead FIFO drained by a valid/ready reader.
- Also reports the per-window byte count and error flags.

Parameters:
- SAMPLE_DELAY, 6: MCLK cycles after the detected CLKOUT rising edge at which DOUT is sampled. Range 0..11.
- FIFO_DEPTH, 16: byte FIFO depth. Power of two, >= 2.
- CNT_W, 13: width of BYTECNT.

Ports:
- MCLK  in  1  48 MHz clock
- RST  in  1  asynchronous, active-high reset
- CLKOUT  in  1  4 MHz clock from emulator core, synchronous to MCLK
- nGATE  in  1  capture window, active low
- DOUT0..DOUT3  in  1 each  bubble data lines (DOUTn maps to nibble bit n)
- RDDATA  out  8  head-of-FIFO byte
- RDVALID  out  1  FIFO non-empty
- RDREADY  in  1  reader accepts RDDATA when RDVALID & RDREADY
- BYTECNT  out  CNT_W  bytes completed in current/last window, saturating
- OVERFLOW  out  1  sticky: a completed byte was dropped because FIFO was full
- PARTIAL  out  1  sticky: window closed with an unpaired nibble
- nBUSY  out  1  low while state is CAPTURE

Behaviour:
- Reset values: RDDATA=0, RDVALID=0, BYTECNT=0, OVERFLOW=0, PARTIAL=0, nBUSY=1, FIFO empty, state IDLE, nibble phase 0, delay counter idle.
- All control is synchronous to MCLK except RST.
- Edge detect: CLKOUT is registered once. A rise is flagged when CLKOUT=1 and the registered value is 0.
- Delay counter: loads SAMPLE_DELAY on a rise and decrements. The sample strobe fires when it reaches 0; with SAMPLE_DELAY=0 the strobe fires in the rise cycle. A new rise while counting reloads the counter; the pending sample is lost (a documented misuse case).
- nGATE is registered once and used for window decisions.
- FSM IDLE: on registered nGATE falling (1->0), clear BYTECNT, OVERFLOW, PARTIAL and nibble phase, then go to CAPTURE. The FIFO is not flushed.
- FSM CAPTURE, sample strobe:
  - phase 0: store {DOUT3..DOUT0} into low nibble, set phase 1.
  - phase 1: byte = {DOUT3..0, low nibble}, attempt push, set phase 0.
- FSM CAPTURE, registered nGATE high: go to CLOSE. A strobe in the same cycle is ignored.
- FSM CLOSE: if phase=1, set PARTIAL. Clear phase, go to IDLE. One cycle.
- Push:
  - If FIFO is not full, or a pop occurs in the same cycle: write the byte and increment BYTECNT (saturating at all-ones).
  - Otherwise: drop the byte, set OVERFLOW, leave BYTECNT unchanged.
- Pop occurs when RDVALID & RDREADY.
- Simultaneous push and pop when full: both succeed, occupancy unchanged.
- Simultaneous push and pop when empty: the push is written. Nothing is popped because RDVALID was 0.
- Latency: a byte pushed in cycle N gives RDVALID=1 and valid RDDATA in cycle N+1.
- RDDATA holds its last value when empty.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from MSB compare.
- The FIFO keeps accepting pops in every state.
- Reset mid-capture: everything returns to reset values immediately, including FIFO contents.

Decomposition:
- Shared package bubble_capture_pkg holds:
  - state enum {IDLE, CAPTURE, CLOSE};
  - NIBBLE_W=4;
  - default SAMPLE_DELAY and FIFO_DEPTH constants.
- One sub-module, capture_fifo: synchronous show-ahead FIFO with push, pop, full, empty, din, dout.
- Edge detect, delay counter, nibble packer and FSM stay in the top.

Test Plan:
- CLKOUT 12-cycle period; nGATE low for 4 CLKOUT cycles; DOUT nibbles 5,A,3,C; RDREADY=1 -> bytes 0xA5 then 0xC3, BYTECNT=2, OVERFLOW=0, PARTIAL=0.
- RDREADY=0, FIFO_DEPTH=16, 34 nibbles captured -> 16 bytes queued, OVERFLOW=1, BYTECNT=16. Then drain: exactly 16 bytes in order, RDVALID drops after the last.
- FIFO full, push strobe coincident with RDREADY=1 -> no overflow, occupancy stays 16, BYTECNT increments.
- Window of 3 nibbles -> one byte queued, PARTIAL=1 after CLOSE. Next window's nGATE fall clears PARTIAL and BYTECNT, and its first nibble lands in the low nibble.
- SAMPLE_DELAY=0 vs 11, DOUT changed at MCLK cycle 6 after each rise -> delay 0 captures the pre-change value, delay 11 captures the post-change value.
- RST pulsed mid-window with 3 bytes queued -> RDVALID=0, BYTECNT=0, nBUSY=1 the following cycle. No capture resumes until a new nGATE fall.

Source files
------------

// File: rtl/bubble_capture_pkg.sv
// Shared types and defaults for the bubble DOUT capture block.
package bubble_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        CLOSE
    } state_e;

    localparam int NIBBLE_W             = 4;
    localparam int DEFAULT_SAMPLE_DELAY = 6;
    localparam int DEFAULT_FIFO_DEPTH   = 16;
    localparam int DEFAULT_CNT_W        = 13;

endpackage

// File: rtl/capture_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on dout while not empty,
// and dout holds the most recently popped value once the FIFO drains.
module capture_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            last_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/bubble_dout_capture.sv
// Captures bubble DOUT nibbles on delayed CLKOUT rises inside the nGATE window,
// packs them into bytes and queues them for a valid/ready reader.
module bubble_dout_capture
    import bubble_capture_pkg::*;
#(
    parameter int SAMPLE_DELAY = DEFAULT_SAMPLE_DELAY,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic             MCLK,
    input  logic             RST,
    input  logic             CLKOUT,
    input  logic             nGATE,
    input  logic             DOUT0,
    input  logic             DOUT1,
    input  logic             DOUT2,
    input  logic             DOUT3,
    output logic [7:0]       RDDATA,
    output logic             RDVALID,
    input  logic             RDREADY,
    output logic [CNT_W-1:0] BYTECNT,
    output logic             OVERFLOW,
    output logic             PARTIAL,
    output logic             nBUSY
);
    localparam int BYTE_W = 2 * NIBBLE_W;
    localparam logic [3:0]       DELAY_LD = 4'(SAMPLE_DELAY);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e                state_q, state_d;
    logic                  clkout_q;
    logic                  ngate_q, ngate_prev_q;
    logic [3:0]            dly_q, dly_d;
    logic                  phase_q, phase_d;
    logic [NIBBLE_W-1:0]   low_q, low_d;
    logic [CNT_W-1:0]      bytecnt_q, bytecnt_d;
    logic                  overflow_q, overflow_d;
    logic                  partial_q, partial_d;

    logic                  rise, strobe;
    logic                  push_req, push_ok;
    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [NIBBLE_W-1:0]   dout_nib;
    logic [BYTE_W-1:0]     byte_in;

    assign dout_nib = {DOUT3, DOUT2, DOUT1, DOUT0};
    assign byte_in  = {dout_nib, low_q};
    assign rise     = CLKOUT && !clkout_q;
    assign fifo_pop = RDREADY && !fifo_empty;

    // A rise always restarts the countdown, so a rise arriving mid-count drops the pending sample.
    always_comb begin
        dly_d  = dly_q;
        strobe = 1'b0;
        if (rise) begin
            dly_d  = DELAY_LD;
            strobe = (DELAY_LD == 4'd0);
        end else if (dly_q != 4'd0) begin
            dly_d  = dly_q - 4'd1;
            strobe = (dly_q == 4'd1);
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        low_d      = low_q;
        bytecnt_d  = bytecnt_q;
        overflow_d = overflow_q;
        partial_d  = partial_q;
        push_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ngate_q && ngate_prev_q) begin
                    bytecnt_d  = '0;
                    overflow_d = 1'b0;
                    partial_d  = 1'b0;
                    phase_d    = 1'b0;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                if (ngate_q) begin
                    state_d = CLOSE;
                end else if (strobe) begin
                    if (!phase_q) begin
                        low_d   = dout_nib;
                        phase_d = 1'b1;
                    end else begin
                        push_req = 1'b1;
                        phase_d  = 1'b0;
                    end
                end
            end
            CLOSE: begin
                if (phase_q) begin
                    partial_d = 1'b1;
                end
                phase_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        push_ok = push_req && (!fifo_full || fifo_pop);
        if (push_ok) begin
            if (bytecnt_q != CNT_MAX) begin
                bytecnt_d = bytecnt_q + CNT_ONE;
            end
        end else if (push_req) begin
            overflow_d = 1'b1;
        end
    end

    // Registered nGATE resets low so a window held open across reset is not seen as a new fall.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            clkout_q     <= 1'b0;
            ngate_q      <= 1'b0;
            ngate_prev_q <= 1'b0;
            dly_q        <= 4'd0;
            phase_q      <= 1'b0;
            low_q        <= '0;
            bytecnt_q    <= '0;
            overflow_q   <= 1'b0;
            partial_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clkout_q     <= CLKOUT;
            ngate_q      <= nGATE;
            ngate_prev_q <= ngate_q;
            dly_q        <= dly_d;
            phase_q      <= phase_d;
            low_q        <= low_d;
            bytecnt_q    <= bytecnt_d;
            overflow_q   <= overflow_d;
            partial_q    <= partial_d;
        end
    end

    capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DATA_W(BYTE_W)
    ) u_fifo (
        .clk  (MCLK),
        .rst  (RST),
        .push (push_ok),
        .pop  (RDREADY),
        .din  (byte_in),
        .full (fifo_full),
        .empty(fifo_empty),
        .dout (RDDATA)
    );

    assign RDVALID  = !fifo_empty;
    assign BYTECNT  = bytecnt_q;
    assign OVERFLOW = overflow_q;
    assign PARTIAL  = partial_q;
    assign nBUSY    = (state_q != CAPTURE);

endmodule
